// File: rtl/mod4051_digit_reducer_pkg.sv
// mod4051_pkg: shared constants, types and FSM states for the mod-4051 datapath
package mod4051_pkg;
  localparam int MODULUS = 4051;
  localparam int RES_W = 12;
  localparam int DIGIT_W = 6;
  localparam int FOLD_K = 4096 - MODULUS;
  localparam int MAX_DIGITS = 84;
  typedef logic [RES_W-1:0] residue_t;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [6:0] cnt_t;
  typedef enum logic {ACC, HOLD} state_t;
endpackage

// File: rtl/mod4051_digit_reducer_if.sv
// mod4051_digit_reducer_if: digit stream in, residue result out
interface mod4051_digit_reducer_if;
  import mod4051_pkg::*;
  logic s_valid;
  logic s_ready;
  digit_t s_digit;
  logic s_last;
  logic m_valid;
  logic m_ready;
  residue_t m_residue;
  logic m_ovf;
  modport master (output s_valid, s_digit, s_last, m_ready, input s_ready, m_valid, m_residue, m_ovf);
  modport slave (input s_valid, s_digit, s_last, m_ready, output s_ready, m_valid, m_residue, m_ovf);
endinterface

// File: rtl/mod4051_digit_reducer_fold.sv
// mod4051_fold: reduces an 18-bit value below 4051*64 to its residue mod 4051
module mod4051_fold
  import mod4051_pkg::*;
(
  input  logic [17:0] t,
  output residue_t    r
);
  logic [12:0] u;
  // 4096 == 45 (mod 4051), so the top bits fold back in; u stays below 2*MODULUS
  assign u = 13'(t[17:12]) * 13'(FOLD_K) + 13'(t[11:0]);
  assign r = u >= 13'(MODULUS) ? residue_t'(u - 13'(MODULUS)) : residue_t'(u);
endmodule

// File: rtl/mod4051_digit_reducer.sv
// mod4051_digit_reducer: Horner accumulation of MSB-first 6-bit digits mod 4051
module mod4051_digit_reducer
  import mod4051_pkg::*;
(
  input logic clk,
  input logic rst,
  mod4051_digit_reducer_if.slave bus
);
  state_t state, state_n;
  residue_t acc, acc_n, residue;
  cnt_t cnt;
  logic ovf, ovf_n, ovf_out, xfer;
  mod4051_fold u_fold (.t({acc, bus.s_digit}), .r(acc_n));
  assign xfer = bus.s_valid && state == ACC;
  assign ovf_n = ovf || cnt == cnt_t'(MAX_DIGITS);
  assign bus.s_ready = state == ACC;
  assign bus.m_valid = state == HOLD;
  assign bus.m_residue = residue;
  assign bus.m_ovf = ovf_out;
  always_comb begin
    state_n = state;
    state_n = state == ACC ? (xfer && bus.s_last ? HOLD : ACC) : (bus.m_ready ? ACC : HOLD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      residue <= '0;
      ovf_out <= 1'b0;
    end else begin
      state <= state_n;
      if (xfer && bus.s_last) begin
        residue <= acc_n;
        ovf_out <= ovf_n;
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (xfer) begin
        acc <= acc_n;
        cnt <= cnt == cnt_t'(MAX_DIGITS + 1) ? cnt : cnt + cnt_t'(1);
        ovf <= ovf_n;
      end
    end
  end
endmodule
